// File: rtl/bullet_mover_if.sv
// Bundle between the game logic and the bullet motion controller: launch
// controls and event inputs one way, renderer position/requests and status
// the other way.
interface bullet_mover_if;
    logic       frame_tick;
    logic       fire;
    logic [8:0] ship_x;
    logic [7:0] ship_y;
    logic       collision;
    logic [8:0] pos_x;
    logic [7:0] pos_y;
    logic       clk_draw;
    logic       clk_erase;
    logic       active;
    logic       done;
    logic       hit;

    // Game-logic side: drives launch/events, observes the bullet.
    modport master (
        output frame_tick, fire, ship_x, ship_y, collision,
        input  pos_x, pos_y, clk_draw, clk_erase, active, done, hit
    );

    // Controller side.
    modport slave (
        input  frame_tick, fire, ship_x, ship_y, collision,
        output pos_x, pos_y, clk_draw, clk_erase, active, done, hit
    );
endinterface

// File: rtl/bullet_mover.sv
// Player bullet motion controller. Launches a bullet from the ship position,
// steps it upward every FRAMES_PER_STEP frame ticks, and issues one-cycle
// draw/erase requests to the pixel renderer with a fixed render window after
// each request. Retires the bullet at the top of the screen or on collision.
module bullet_mover #(
    parameter int STEP_Y          = 2,
    parameter int TOP_Y           = 0,
    parameter int FRAMES_PER_STEP = 1,
    parameter int RENDER_CYCLES   = 8
) (
    input  logic          clk,
    input  logic          reset,
    bullet_mover_if.slave bus
);
    localparam int                WAIT_W     = $clog2(RENDER_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(RENDER_CYCLES - 1);
    localparam logic [3:0]        FRAME_LAST = 4'(FRAMES_PER_STEP - 1);
    // Retirement threshold compared on 9 bits so pos_y never wraps below 0.
    localparam logic [8:0]        RETIRE_Y   = 9'(TOP_Y + STEP_Y);
    localparam logic [7:0]        STEP       = 8'(STEP_Y);

    typedef enum logic [1:0] {IDLE, DRAW, HOLD, ERASE} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [3:0]        frame_cnt, frame_nxt;
    logic              kill, kill_nxt;
    logic              kill_eff;
    logic              wait_last;
    logic [8:0]        pos_x_q, pos_x_nxt;
    logic [7:0]        pos_y_q, pos_y_nxt;
    logic              draw_q, draw_nxt;
    logic              erase_q, erase_nxt;
    logic              active_q;
    logic              done_q, done_nxt;
    logic              hit_q, hit_nxt;

    // State, counters, kill flag and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            frame_cnt <= '0;
            kill      <= 1'b0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            draw_q    <= 1'b0;
            erase_q   <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            frame_cnt <= frame_nxt;
            kill      <= kill_nxt;
            pos_x_q   <= pos_x_nxt;
            pos_y_q   <= pos_y_nxt;
            draw_q    <= draw_nxt;
            erase_q   <= erase_nxt;
            active_q  <= (state_nxt != IDLE);
            done_q    <= done_nxt;
            hit_q     <= hit_nxt;
        end
    end

    // Next-state, counter and output decode; a collision arriving this cycle
    // acts as if the kill flag were already set so HOLD reacts in one cycle.
    always_comb begin
        state_nxt = state;
        wait_nxt  = '0;
        frame_nxt = '0;
        kill_nxt  = kill;
        pos_x_nxt = pos_x_q;
        pos_y_nxt = pos_y_q;
        done_nxt  = 1'b0;
        hit_nxt   = 1'b0;
        kill_eff  = kill | bus.collision;
        wait_last = (wait_cnt == WAIT_LAST);

        case (state)
            IDLE: begin
                if (bus.fire) begin
                    state_nxt = DRAW;
                    pos_x_nxt = bus.ship_x;
                    pos_y_nxt = bus.ship_y;
                    kill_nxt  = 1'b0;
                end
            end
            DRAW: begin
                kill_nxt = kill_eff;
                if (wait_last) begin
                    state_nxt = kill_eff ? ERASE : HOLD;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            HOLD: begin
                kill_nxt = kill_eff;
                if (kill_eff) begin
                    state_nxt = ERASE;
                end else if (bus.frame_tick) begin
                    if (frame_cnt == FRAME_LAST) begin
                        state_nxt = ERASE;
                    end else begin
                        frame_nxt = frame_cnt + 1'b1;
                    end
                end else begin
                    frame_nxt = frame_cnt;
                end
            end
            ERASE: begin
                kill_nxt = kill_eff;
                if (wait_last) begin
                    if (kill_eff || ({1'b0, pos_y_q} < RETIRE_Y)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        hit_nxt   = kill_eff;
                    end else begin
                        state_nxt = DRAW;
                        pos_y_nxt = pos_y_q - STEP;
                    end
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Requests fire only on the first cycle of their window.
        draw_nxt  = (state_nxt == DRAW)  && (state != DRAW);
        erase_nxt = (state_nxt == ERASE) && (state != ERASE);
    end

    assign bus.pos_x     = pos_x_q;
    assign bus.pos_y     = pos_y_q;
    assign bus.clk_draw  = draw_q;
    assign bus.clk_erase = erase_q;
    assign bus.active    = active_q;
    assign bus.done      = done_q;
    assign bus.hit       = hit_q;
endmodule

// File: tb/tb_bullet_mover.sv
// Bench for bullet_mover: a default instance driven through launch, step,
// top exit, collision, ignored-input and mid-flight reset sequences, plus a
// FRAMES_PER_STEP=3 instance for tick counting.
module tb_bullet_mover;
    localparam int R        = 8;
    localparam int EV_DRAW  = 0;
    localparam int EV_ERASE = 1;
    localparam int EV_DONE  = 2;

    typedef struct {
        int         kind;
        logic [8:0] x;
        logic [7:0] y;
        logic       hit;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   erase3 = 0;
    ev_t  sb[$];
    logic [8:0] prev_x;
    logic [7:0] prev_y;

    bullet_mover_if bif ();
    bullet_mover_if bif3 ();

    bullet_mover dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    bullet_mover #(.FRAMES_PER_STEP(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input logic [8:0] x, input logic [7:0] y, input logic hit);
        ev_t e;
        e.kind = kind;
        e.x    = x;
        e.y    = y;
        e.hit  = hit;
        sb.push_back(e);
    endtask

    task automatic expect_ev(input int kind);
        ev_t e;
        chk("sb_event_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_kind", kind, e.kind);
            if (kind == EV_DONE) begin
                chk("sb_hit", 32'(bif.hit), 32'(e.hit));
            end else begin
                chk("sb_pos_x", 32'(bif.pos_x), 32'(e.x));
                chk("sb_pos_y", 32'(bif.pos_y), 32'(e.y));
            end
        end
    endtask

    function automatic logic ev_hit(input int kind);
        case (kind)
            EV_DRAW:  return bif.clk_draw;
            EV_ERASE: return bif.clk_erase;
            default:  return bif.done;
        endcase
    endfunction

    task automatic wait_ev(input int kind, input int limit, input string tag);
        int n;
        n = 0;
        while (!ev_hit(kind) && n < limit) begin
            tick();
            n++;
        end
        chk({tag, "_arrived"}, 32'(ev_hit(kind)), 1);
    endtask

    // Scoreboard monitor: every request/retirement must match the next expected event.
    always @(negedge clk) begin
        if (!reset) begin
            if (bif.clk_draw)  expect_ev(EV_DRAW);
            if (bif.clk_erase) expect_ev(EV_ERASE);
            if (bif.done)      expect_ev(EV_DONE);
            if (bif.clk_draw)  chk("draw_erase_overlap", 32'(bif.clk_erase), 0);
            if (bif.hit)       chk("hit_without_done", 32'(bif.done), 1);
            if (!bif.clk_draw && ({bif.pos_x, bif.pos_y} != {prev_x, prev_y}))
                chk("pos_stable", 32'({bif.pos_x, bif.pos_y}), 32'({prev_x, prev_y}));
            if (bif3.clk_erase) erase3++;
        end
        prev_x = bif.pos_x;
        prev_y = bif.pos_y;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_draw;
        int t_erase;
        bif.fire = 0;  bif.frame_tick = 0;  bif.collision = 0;  bif.ship_x = 0;  bif.ship_y = 0;
        bif3.fire = 0; bif3.frame_tick = 0; bif3.collision = 0; bif3.ship_x = 0; bif3.ship_y = 0;

        // Reset values
        tick();
        tick();
        chk("rst_pos_x", 32'(bif.pos_x), 0);
        chk("rst_pos_y", 32'(bif.pos_y), 0);
        chk("rst_draw", 32'(bif.clk_draw), 0);
        chk("rst_erase", 32'(bif.clk_erase), 0);
        chk("rst_active", 32'(bif.active), 0);
        chk("rst_done", 32'(bif.done), 0);
        chk("rst_hit", 32'(bif.hit), 0);
        chk("rst_active3", 32'(bif3.active), 0);
        reset = 1'b0;
        repeat (50) tick();
        chk("idle_active", 32'(bif.active), 0);
        chk("idle_sb_empty", sb.size(), 0);

        // Launch and one step
        bif.ship_x = 100;
        bif.ship_y = 200;
        push_ev(EV_DRAW, 100, 200, 0);
        bif.fire = 1;
        tick();
        bif.fire = 0;
        chk("launch_draw", 32'(bif.clk_draw), 1);
        chk("launch_x", 32'(bif.pos_x), 100);
        chk("launch_y", 32'(bif.pos_y), 200);
        chk("launch_active", 32'(bif.active), 1);
        tick();
        chk("draw_one_cycle", 32'(bif.clk_draw), 0);
        repeat (R + 1) tick();
        push_ev(EV_ERASE, 100, 200, 0);
        bif.frame_tick = 1;
        tick();
        bif.frame_tick = 0;
        chk("tick_erase", 32'(bif.clk_erase), 1);
        t_erase = cyc;
        push_ev(EV_DRAW, 100, 198, 0);
        wait_ev(EV_DRAW, 20, "step_draw");
        chk("step_gap", cyc - t_erase, R);
        chk("step_y", 32'(bif.pos_y), 198);

        // Two-cycle collision during HOLD
        repeat (R + 2) tick();
        push_ev(EV_ERASE, 100, 198, 0);
        push_ev(EV_DONE, 0, 0, 1);
        bif.collision = 1;
        tick();
        chk("coll_erase", 32'(bif.clk_erase), 1);
        t_erase = cyc;
        tick();
        bif.collision = 0;
        wait_ev(EV_DONE, 20, "coll_done");
        chk("coll_done_gap", cyc - t_erase, R);
        chk("coll_hit", 32'(bif.hit), 1);
        chk("coll_inactive", 32'(bif.active), 0);
        repeat (20) tick();
        chk("coll_sb_empty", sb.size(), 0);

        // Fire ignored while active, collision during DRAW
        bif.ship_x = 50;
        bif.ship_y = 10;
        push_ev(EV_DRAW, 50, 10, 0);
        bif.fire = 1;
        tick();
        bif.fire = 0;
        chk("l2_draw", 32'(bif.clk_draw), 1);
        t_draw = cyc;
        bif.ship_x = 300;
        bif.ship_y = 77;
        bif.fire = 1;
        tick();
        bif.fire = 0;
        tick();
        chk("fire_ignored_x", 32'(bif.pos_x), 50);
        chk("fire_ignored_y", 32'(bif.pos_y), 10);
        push_ev(EV_ERASE, 50, 10, 0);
        push_ev(EV_DONE, 0, 0, 1);
        bif.collision = 1;
        tick();
        bif.collision = 0;
        wait_ev(EV_ERASE, 20, "dcoll_erase");
        chk("dcoll_gap", cyc - t_draw, R);
        wait_ev(EV_DONE, 20, "dcoll_done");
        chk("dcoll_hit", 32'(bif.hit), 1);
        repeat (5) tick();

        // Top exit with fire and frame_tick held high, then relaunch
        bif.ship_x = 7;
        bif.ship_y = 3;
        push_ev(EV_DRAW, 7, 3, 0);
        push_ev(EV_ERASE, 7, 3, 0);
        push_ev(EV_DRAW, 7, 1, 0);
        push_ev(EV_ERASE, 7, 1, 0);
        push_ev(EV_DONE, 0, 0, 0);
        push_ev(EV_DRAW, 7, 3, 0);
        bif.fire = 1;
        bif.frame_tick = 1;
        wait_ev(EV_DONE, 100, "top_done");
        chk("top_hit", 32'(bif.hit), 0);
        chk("top_y_no_wrap", 32'(bif.pos_y), 1);
        tick();
        chk("relaunch_draw", 32'(bif.clk_draw), 1);
        chk("relaunch_y", 32'(bif.pos_y), 3);
        bif.fire = 0;
        bif.frame_tick = 0;

        // Asynchronous reset during the ERASE window
        repeat (R + 2) tick();
        push_ev(EV_ERASE, 7, 3, 0);
        bif.frame_tick = 1;
        tick();
        bif.frame_tick = 0;
        chk("mr_erase", 32'(bif.clk_erase), 1);
        repeat (3) tick();
        #3;
        reset = 1'b1;
        #1;
        chk("mr_pos_x", 32'(bif.pos_x), 0);
        chk("mr_pos_y", 32'(bif.pos_y), 0);
        chk("mr_active", 32'(bif.active), 0);
        chk("mr_erase_low", 32'(bif.clk_erase), 0);
        chk("mr_sb_empty", sb.size(), 0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("mr_still_idle", 32'(bif.active), 0);
        bif.ship_x = 20;
        bif.ship_y = 40;
        push_ev(EV_DRAW, 20, 40, 0);
        bif.fire = 1;
        tick();
        bif.fire = 0;
        chk("mr_relaunch", 32'(bif.clk_draw), 1);
        chk("mr_relaunch_x", 32'(bif.pos_x), 20);
        push_ev(EV_ERASE, 20, 40, 0);
        push_ev(EV_DONE, 0, 0, 1);
        bif.collision = 1;
        tick();
        bif.collision = 0;
        wait_ev(EV_DONE, 30, "mr_done");
        repeat (3) tick();
        chk("final_sb_empty", sb.size(), 0);

        // FRAMES_PER_STEP=3: ticks in DRAW/ERASE dropped, step on every 3rd HOLD tick
        bif3.ship_x = 10;
        bif3.ship_y = 100;
        bif3.fire = 1;
        tick();
        bif3.fire = 0;
        chk("d3_draw", 32'(bif3.clk_draw), 1);
        chk("d3_y", 32'(bif3.pos_y), 100);
        for (int i = 0; i < 3; i++) begin
            bif3.frame_tick = 1;
            tick();
            bif3.frame_tick = 0;
            tick();
        end
        repeat (4) tick();
        chk("d3_draw_ticks_dropped", erase3, 0);
        for (int i = 0; i < 2; i++) begin
            bif3.frame_tick = 1;
            tick();
            bif3.frame_tick = 0;
            tick();
        end
        chk("d3_two_ticks", erase3, 0);
        chk("d3_active", 32'(bif3.active), 1);
        bif3.frame_tick = 1;
        tick();
        bif3.frame_tick = 0;
        chk("d3_third_tick", 32'(bif3.clk_erase), 1);
        t_erase = cyc;
        for (int i = 0; i < 3; i++) begin
            bif3.frame_tick = 1;
            tick();
            bif3.frame_tick = 0;
            tick();
        end
        begin
            int n;
            n = 0;
            while (!bif3.clk_draw && n < 20) begin
                tick();
                n++;
            end
        end
        chk("d3_redraw", 32'(bif3.clk_draw), 1);
        chk("d3_redraw_gap", cyc - t_erase, R);
        chk("d3_step_y", 32'(bif3.pos_y), 98);
        repeat (R + 2) tick();
        for (int i = 0; i < 2; i++) begin
            bif3.frame_tick = 1;
            tick();
            bif3.frame_tick = 0;
            tick();
        end
        chk("d3_erase_ticks_dropped", erase3, 1);
        bif3.frame_tick = 1;
        tick();
        bif3.frame_tick = 0;
        chk("d3_second_step", 32'(bif3.clk_erase), 1);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bullet_mover.md
# bullet_mover

Motion controller sitting directly upstream of the bullet pixel renderer. Launches a player bullet from the ship position on `fire` and steps it upward once per N frame ticks. Drives the renderer's position inputs and its one-cycle draw/erase requests, and retires the bullet at the top of the screen or on collision. Outputs `pos_x`, `pos_y`, `clk_draw` and `clk_erase` connect one-to-one to the renderer's `pos_x`, `pos_y`, `clk_draw` and `clk_erase`.

## Interface
- `STEP_Y`, 2: pixels moved up per step.
- `TOP_Y`, 0: topmost legal `pos_y`.
- `FRAMES_PER_STEP`, 1: frame ticks between steps (1..15).
- `RENDER_CYCLES`, 8: cycles reserved after each draw/erase request for the renderer to finish. Must be ≥7.
- `clk`  in  1  system clock (single clock domain).
- `reset`  in  1  **asynchronous, active-high** reset.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `fire`  in  1  launch request; level, sampled only in IDLE.
- `ship_x`  in  9  ship x at launch.
- `ship_y`  in  8  ship y at launch.
- `collision`  in  1  hit indication; may be a pulse of any width.
- `pos_x`  out  9  bullet anchor x.
- `pos_y`  out  8  bullet anchor y.
- `clk_draw`  out  1  one-cycle draw request.
- `clk_erase`  out  1  one-cycle erase request.
- `active`  out  1  a bullet is in flight (state ≠ IDLE).
- `done`  out  1  one-cycle pulse on retirement.
- `hit`  out  1  qualifies `done`: 1 if retired by collision.

## Operation
States and transitions:
- **IDLE**: `active`=0.
  - `fire`=1 → load `pos_x`←`ship_x`, `pos_y`←`ship_y`, clear kill flag → DRAW.
- **DRAW**: `clk_draw`=1 on the first cycle only. Wait counter runs `RENDER_CYCLES` cycles.
  - Then → ERASE if kill flag set, else → HOLD.
- **HOLD**: counts `frame_tick` pulses.
  - Count reaching `FRAMES_PER_STEP` → ERASE; frame counter clears.
  - Kill flag set → ERASE immediately.
- **ERASE**: `clk_erase`=1 on the first cycle only. Waits `RENDER_CYCLES` cycles with position held.
  - Then, if kill flag set or `pos_y` < `TOP_Y`+`STEP_Y` (9-bit compare, no wrap) → IDLE with `done`=1 and `hit`=kill flag.
  - Else `pos_y`←`pos_y`−`STEP_Y` → DRAW.

Rules:
- `pos_x` and `pos_y` change only on IDLE→DRAW and on ERASE→DRAW. They are stable through every draw/erase window.
- `collision` is latched into the kill flag in any non-IDLE state; it is ignored in IDLE. The flag is cleared on launch.
- `fire` is ignored while `active`=1. There is no queuing.
- `frame_tick` is counted only in HOLD; ticks arriving in DRAW or ERASE are dropped.
- `collision` and `frame_tick` arriving in the same HOLD cycle → ERASE; the retirement is a hit (`hit`=1).
- `fire` held high across retirement relaunches on the first IDLE cycle after `done`.

## Timing
- All outputs are registered. Reset values: `pos_x`=0, `pos_y`=0, `clk_draw`=0, `clk_erase`=0, `active`=0, `done`=0, `hit`=0, state=IDLE, counters=0.
- `fire` sampled high at edge E (in IDLE) → at E+1 `pos` is valid and `clk_draw`=1 and `active`=1.
- `clk_draw` and `clk_erase` are each exactly 1 cycle wide. They are never both high.
- Consecutive requests (draw→erase, erase→draw) are separated by ≥`RENDER_CYCLES` cycles.
- `frame_tick` at edge F in HOLD that completes the count → `clk_erase`=1 at F+1.
- Collision latency: HOLD → `clk_erase` 1 cycle after `collision`. During DRAW, the erase follows immediately after the draw window ends.
- On ERASE→DRAW, the new `pos_y` appears in the same cycle `clk_draw` rises.
- `done` and `hit` are 1 cycle wide, in the first IDLE cycle; `hit`=0 whenever `done`=0.
- Reset asserted mid-flight forces reset values immediately, independent of `clk`. No erase is issued.

## Test plan
- Reset values: assert `reset` → every output 0. Release, no stimulus for 50 cycles → `active`=0 and no requests issued.
- Launch: `ship_x`=100, `ship_y`=200, pulse `fire` → next cycle `pos`=(100,200), `clk_draw`=1 for 1 cycle. First `frame_tick` → `clk_erase`. After the ERASE window, `pos_y`=198 with `clk_draw`=1 in the same cycle.
- Top exit: launch at `ship_y`=3, `STEP_Y`=2. Steps go 3→1; the next erase retires it with `done`=1, `hit`=0, and `pos_y` never wraps to 255.
- Collision: 2-cycle `collision` pulse during HOLD → `clk_erase` next cycle, then `done`=`hit`=1 and no further `clk_draw`. A collision pulse during DRAW → erase right after the draw window, then `hit`=1.
- Ignored inputs: `fire` pulsed while `active`=1 → `pos_x` unchanged and no extra `clk_draw`. With `FRAMES_PER_STEP`=3, a step occurs only on every 3rd HOLD tick, and ticks during DRAW/ERASE are not counted.
- Mid-flight reset: assert `reset` asynchronously during the ERASE wait → outputs go to 0 immediately. After release, `fire` relaunches normally.
